// File: rtl/mas_serial_adder_ctrl.sv
// Serial W-bit adder: one 4-bit ripple-carry adder is time-shared over W/4
// nibble cycles, with a valid/ready handshake on both sides.

module mas_ripple_carry_adder_4b (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] res,
  output logic       co
);
  logic [4:0] c;

  always_comb begin
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      res[i]   = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    co = c[4];
  end
endmodule

module mas_serial_adder_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NIB = W / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [NIB-1:0][3:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                  cin_q, cin_d, carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [3:0] add_x, add_y, add_res;
  logic       add_ci, add_co;

  // The first nibble takes the captured carry-in; later nibbles chain the carry register.
  assign add_x  = a_q[cnt_q];
  assign add_y  = b_q[cnt_q];
  assign add_ci = (cnt_q == '0) ? cin_q : carry_q;

  mas_ripple_carry_adder_4b u_add (
    .x   (add_x),
    .y   (add_y),
    .ci  (add_ci),
    .res (add_res),
    .co  (add_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cin_d     = cin_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[cnt_q] = add_res;
        carry_d      = add_co;
        // Counter parks on the last nibble rather than wrapping.
        if (cnt_q == CW'(NIB - 1)) begin
          cout_d  = add_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_mas_serial_adder_ctrl.sv
// Bench for mas_serial_adder_ctrl: directed W=16 cases, then random back-to-back
// traffic on W=4/16/32 scored against plain a+b+cin arithmetic.

module tb_mas_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        mon_on = 1'b0;
  int          cyc = 0;
  int          n_pass = 0, n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WG = (g == 0) ? 4 : ((g == 1) ? 16 : 32);
    logic          in_ready, out_valid, cout;
    logic [WG-1:0] sum;
    logic [WG:0]   q[$];
    int            n_res = 0, last_cyc = 0;

    mas_serial_adder_ctrl #(.W(WG)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a[WG-1:0]),
      .b         (b[WG-1:0]),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
    );

    // Scoreboard: every accepted operand set queues its exact sum; results must
    // come back in order, one every WG/4+2 cycles.
    always @(negedge clk) begin
      if (mon_on) begin
        if (out_valid && out_ready) begin
          chk($sformatf("w%0d_sb_nonempty", WG), q.size() != 0, 1);
          if (q.size() != 0) begin
            automatic logic [WG:0] e = q.pop_front();
            chk($sformatf("w%0d_sum", WG), sum, e[WG-1:0]);
            chk($sformatf("w%0d_cout", WG), cout, e[WG]);
          end
          if (n_res > 0) chk($sformatf("w%0d_gap", WG), cyc - last_cyc, WG / 4 + 2);
          last_cyc = cyc;
          n_res++;
        end
        if (in_valid && in_ready) begin
          automatic logic [63:0] m = (64'd1 << WG) - 64'd1;
          automatic logic [63:0] s = (64'(a) & m) + (64'(b) & m) + 64'(cin);
          q.push_back(s[WG:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // lat counts rising edges from the accepting edge (counted as 1) until out_valid is seen.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                        input bit chg, output int lat);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    chk("busy_in_ready", g_dut[1].in_ready, 0);
    if (chg) begin
      a = $urandom; b = $urandom; cin = 1'b1; out_ready = 1'b1;
    end
    while (!g_dut[1].out_valid && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit seen;

    // Reset state
    tick; tick;
    chk("rst_in_ready", g_dut[1].in_ready, 1);
    chk("rst_out_valid", g_dut[1].out_valid, 0);
    chk("rst_sum", g_dut[1].sum, 0);
    chk("rst_cout", g_dut[1].cout, 0);
    rst = 1'b0;
    tick;

    // 0x1234 + 0x4321
    run_op(32'h1234, 32'h4321, 1'b0, 1'b0, lat);
    chk("lat_1234", lat, 5);
    chk("sum_1234", g_dut[1].sum, 16'h5555);
    chk("cout_1234", g_dut[1].cout, 0);
    out_ready = 1'b1; tick; out_ready = 1'b0;
    chk("idle_after_1234", g_dut[1].in_ready, 1);

    // Carry ripples through every nibble
    run_op(32'hFFFF, 32'h0000, 1'b1, 1'b0, lat);
    chk("lat_ripple", lat, 5);
    chk("sum_ripple", g_dut[1].sum, 16'h0000);
    chk("cout_ripple", g_dut[1].cout, 1);
    out_ready = 1'b1; tick; out_ready = 1'b0;

    // Max operands, consumer stalls for 3 cycles
    run_op(32'hFFFF, 32'hFFFF, 1'b1, 1'b0, lat);
    chk("lat_max", lat, 5);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_out_valid", g_dut[1].out_valid, 1);
      chk("stall_in_ready", g_dut[1].in_ready, 0);
      chk("stall_sum", g_dut[1].sum, 16'hFFFF);
      chk("stall_cout", g_dut[1].cout, 1);
    end
    out_ready = 1'b1; tick; out_ready = 1'b0;
    chk("release_out_valid", g_dut[1].out_valid, 0);
    chk("release_in_ready", g_dut[1].in_ready, 1);

    // Inputs disturbed mid-flight, out_ready held high through RUN
    run_op(32'h00FF, 32'h0001, 1'b0, 1'b1, lat);
    chk("lat_chg", lat, 5);
    chk("sum_chg", g_dut[1].sum, 16'h0100);
    chk("cout_chg", g_dut[1].cout, 0);
    tick; out_ready = 1'b0;
    chk("idle_after_chg", g_dut[1].in_ready, 1);

    // Asynchronous abort in the 2nd RUN cycle
    a = 32'h1111; b = 32'h2222; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready", g_dut[1].in_ready, 1);
    chk("abort_out_valid", g_dut[1].out_valid, 0);
    chk("abort_sum", g_dut[1].sum, 0);
    chk("abort_cout", g_dut[1].cout, 0);
    tick;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      seen |= g_dut[1].out_valid;
    end
    chk("abort_no_result", seen, 0);
    run_op(32'h8000, 32'h8000, 1'b0, 1'b0, lat);
    chk("lat_after_abort", lat, 5);
    chk("sum_after_abort", g_dut[1].sum, 16'h0000);
    chk("cout_after_abort", g_dut[1].cout, 1);

    // Random back-to-back traffic on all widths
    rst = 1'b1; tick; rst = 1'b0;
    mon_on = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = $urandom; b = $urandom; cin = 1'(($urandom_range(0, 1)));
    for (int i = 0; i < 10500; i++) begin
      tick;
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    end
    tick;
    mon_on = 1'b0; in_valid = 1'b0;
    chk("ops_w4", g_dut[0].n_res >= 1000, 1);
    chk("ops_w16", g_dut[1].n_res >= 1000, 1);
    chk("ops_w32", g_dut[2].n_res >= 1000, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mas_serial_adder_ctrl.md
MAS_SERIAL_ADDER_CTRL -- requirements
Module: mas_serial_adder_ctrl

Interface
REQ-001 The module SHALL have parameter W, default 16: operand width in bits; legal values are multiples of 4, minimum 4.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: operand set a/b/cin is valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: controller can accept an operand set.
REQ-006 The module SHALL have port a, input, W bits: first operand.
REQ-007 The module SHALL have port b, input, W bits: second operand.
REQ-008 The module SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-009 The module SHALL have port out_valid, output, 1 bit: sum/cout are valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 The module SHALL have port sum, output, W bits: a + b + cin, modulo 2^W.
REQ-012 The module SHALL have port cout, output, 1 bit: carry out of bit W-1.

Function
REQ-013 The module SHALL compute all additions using exactly one instance of mas_ripple_carry_adder_4b, time-shared one nibble per cycle; no other adder SHALL exist in the datapath, except the nibble counter.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1 the controller SHALL capture a, b and cin into registers, clear the nibble counter, and move to RUN.
REQ-016 RUN: in_ready=0, out_valid=0; at each cycle k (k=0..W/4-1) the adder SHALL receive nibble k of the captured a and b, with carry-in equal to the captured cin for k=0 and otherwise the carry register; res SHALL be written into sum bits [4k+3:4k] and the adder carry-out into the carry register.
REQ-017 After the cycle with k=W/4-1 the FSM SHALL move to DONE, with cout equal to the final carry.
REQ-018 DONE: out_valid=1, in_ready=0; sum and cout SHALL hold stable until out_ready=1, after which the FSM SHALL return to IDLE on that edge.
REQ-019 Latency SHALL be fixed: out_valid asserts exactly W/4+1 cycles after the accepting edge (5 cycles for W=16), independent of operand values.
REQ-020 Input changes while not in IDLE SHALL have no effect on the result in flight.
REQ-021 out_ready asserted outside DONE SHALL be ignored.
REQ-022 in_valid must be registered on the same edge that leaves IDLE; back-to-back throughput SHALL be one result per W/4+2 cycles with out_ready held 1.
REQ-023 The nibble counter SHALL be ceil(log2(W/4)) bits, minimum 1, and SHALL not wrap during RUN.
REQ-024 Arithmetic SHALL be unsigned; overflow is reported only through cout, and sum wraps modulo 2^W.

Reset
REQ-025 While rst=1 the FSM SHALL be in IDLE, with in_ready=1, out_valid=0, sum=0, cout=0, carry register=0 and counter=0, regardless of clk.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no result delivered; the first operation after deassertion SHALL be accepted normally.

Verification
REQ-027 W=16, a=0x1234, b=0x4321, cin=0 accepted -> out_valid exactly 5 cycles later, with sum=0x5555 and cout=0.
REQ-028 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000 and cout=1; the carry must ripple across all 4 nibble cycles.
REQ-029 a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF and cout=1; out_ready held 0 for 3 cycles -> outputs remain stable and in_ready stays 0, then 1 cycle after out_ready=1 the FSM returns to IDLE.
REQ-030 Change a/b during RUN after accepting 0x00FF + 0x0001 -> sum=0x0100 and cout=0, unaffected by the change.
REQ-031 Pulse rst in the 2nd RUN cycle -> outputs at reset values immediately with no out_valid pulse; next 0x8000 + 0x8000 -> sum=0x0000 and cout=1.
REQ-032 Random back-to-back traffic with in_valid and out_ready held 1, 1000 operations, W=4, 16 and 32, checked against a reference a+b+cin model -> one result every W/4+2 cycles, with all results exact.
